// File: rtl/trace_capture.sv
// Circular trace recorder: arm, capture samples, freeze a programmable number of
// samples after a trigger, then stream the window oldest-first over valid/ready.
module trace_capture #(
  parameter int XLEN    = 32,
  parameter int NCH     = 2,
  parameter int DEPTH   = 64,
  parameter int CNT_LEN = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 arm,
  input  logic                 sample_valid,
  input  logic [NCH*XLEN-1:0]  sample_data,
  input  logic                 trig,
  input  logic [CNT_LEN:0]     post_len,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [NCH*XLEN-1:0]  rd_data,
  output logic                 rd_last,
  output logic [CNT_LEN:0]     count,
  output logic [CNT_LEN:0]     trig_idx,
  output logic [1:0]           state
);
  localparam int W = NCH*XLEN;
  localparam logic [CNT_LEN:0] DEPTH_C = (CNT_LEN+1)'(DEPTH);
  localparam logic [CNT_LEN:0] ONE     = (CNT_LEN+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  state_t state_q, state_d;
  logic [W-1:0]       mem [DEPTH];
  logic [CNT_LEN-1:0] wr_ptr, rd_ptr, rd_start;
  logic [CNT_LEN:0]   post_rem, post_written, rd_cnt;
  logic [CNT_LEN:0]   count_nx, post_written_nx, post_clamp;
  logic               rd_active, wr_en, trig_fire, done_entry;

  assign state = state_q;

  always_comb begin
    wr_en      = en && sample_valid && (state_q == ARMED || state_q == POST) && !arm;
    trig_fire  = en && trig && (state_q == ARMED) && !arm;
    // Clamp keeps the trigger entry inside the window once post samples wrap.
    post_clamp = (post_len > DEPTH_C - ONE) ? DEPTH_C - ONE : post_len;
    count_nx   = (wr_en && count != DEPTH_C) ? count + ONE : count;
    post_written_nx = trig_fire ? '0 :
                      (state_q == POST && wr_en) ? post_written + ONE : post_written;
    rd_start   = wr_ptr - count[CNT_LEN-1:0];

    state_d = state_q;
    case (state_q)
      ARMED: if (trig_fire) state_d = (post_clamp == '0) ? DONE : POST;
      POST:  if (wr_en && post_rem == ONE) state_d = DONE;
      DONE: begin
        if (!rd_active && count == '0) state_d = IDLE;
        else if (rd_active && rd_valid && rd_ready && rd_last) state_d = IDLE;
      end
      default: state_d = state_q;
    endcase
    if (arm) state_d = ARMED;
    done_entry = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0; trig_idx <= '0;
      post_rem <= '0; post_written <= '0; rd_cnt <= '0; rd_active <= 1'b0;
      rd_valid <= 1'b0; rd_last <= 1'b0; rd_data <= '0;
    end else if (arm) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0; trig_idx <= '0;
      post_rem <= '0; post_written <= '0; rd_cnt <= '0; rd_active <= 1'b0;
      rd_valid <= 1'b0; rd_last <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      count        <= count_nx;
      post_written <= post_written_nx;
      if (trig_fire) post_rem <= post_clamp;
      else if (state_q == POST && wr_en) post_rem <= post_rem - ONE;
      if (done_entry) trig_idx <= (count_nx == '0) ? '0 : count_nx - ONE - post_written_nx;

      if (state_q == DONE) begin
        if (!rd_active) begin
          // First DONE cycle: point at the oldest entry and present it.
          if (count != '0) begin
            rd_active <= 1'b1;
            rd_valid  <= 1'b1;
            rd_data   <= mem[rd_start];
            rd_last   <= (count == ONE);
            rd_ptr    <= rd_start + 1'b1;
            rd_cnt    <= ONE;
          end
        end else if (rd_valid && rd_ready) begin
          if (rd_last) begin
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_active <= 1'b0;
          end else begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
            rd_last <= (rd_cnt == count - ONE);
            rd_cnt  <= rd_cnt + ONE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture (DEPTH=8, two 8-bit channels); single-channel
// tests keep the upper channel at zero.
module tb_trace_capture;
  localparam int XLEN = 8, NCH = 2, DEPTH = 8, CL = 3;

  logic              clk = 0;
  logic              reset, en, arm, sample_valid, trig, rd_ready;
  logic [NCH*XLEN-1:0] sample_data, rd_data;
  logic [CL:0]       post_len, count, trig_idx;
  logic              rd_valid, rd_last;
  logic [1:0]        state;
  int n_chk = 0, n_err = 0;

  trace_capture #(.XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en), .arm(arm), .sample_valid(sample_valid),
    .sample_data(sample_data), .trig(trig), .post_len(post_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .count(count), .trig_idx(trig_idx), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // All tasks start and end at a negedge.
  task automatic smp(input logic [7:0] hi, input logic [7:0] lo, input bit t);
    sample_valid = 1; sample_data = {hi, lo}; trig = t;
    @(negedge clk);
    sample_valid = 0; trig = 0;
  endtask

  task automatic do_arm();
    arm = 1;
    @(negedge clk);
    arm = 0;
  endtask

  task automatic drain(input logic [7:0] hi, input int first, input int n, input int stall_at);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [15:0] e;
    rd_ready = 1;
    while (got < n && cyc < 60) begin
      e = {hi, 8'(first + got)};
      if (rd_valid && got == stall_at && !stalled) begin
        rd_ready = 0; stalled = 1;
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", 32'(rd_valid), 1);
          chk("stall_data", 32'(rd_data), 32'(e));
        end
        rd_ready = 1;
      end
      if (rd_valid) begin
        chk("rd_data", 32'(rd_data), 32'(e));
        chk("rd_last", 32'(rd_last), 32'(got == n - 1));
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    rd_ready = 0;
    chk("xfers", 32'(got), 32'(n));
    chk("post_rd_valid", 32'(rd_valid), 0);
    chk("post_rd_last", 32'(rd_last), 0);
    chk("post_state", 32'(state), 0);
  endtask

  initial begin
    reset = 1; en = 1; arm = 0; sample_valid = 0; sample_data = '0; trig = 0;
    post_len = '0; rd_ready = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);

    // 1 + 4: basic window with backpressure on entry 3
    post_len = 2;
    do_arm();
    chk("t1_armed", 32'(state), 1);
    for (int k = 1; k <= 5; k++) smp(8'h0, 8'(k), k == 5);
    chk("t1_post", 32'(state), 2);
    smp(8'h0, 8'd6, 0);
    smp(8'h0, 8'd7, 0);
    chk("t1_state", 32'(state), 3);
    chk("t1_count", 32'(count), 7);
    chk("t1_tidx", 32'(trig_idx), 4);
    chk("t1_valid_lat", 32'(rd_valid), 0);
    drain(8'h0, 1, 7, 2);
    chk("t1_count_kept", 32'(count), 7);
    chk("t1_tidx_kept", 32'(trig_idx), 4);

    // 2: wrap-around
    post_len = 3;
    do_arm();
    for (int k = 1; k <= 23; k++) smp(8'h0, 8'(k), k == 20);
    chk("t2_state", 32'(state), 3);
    chk("t2_count", 32'(count), 8);
    chk("t2_tidx", 32'(trig_idx), 4);
    drain(8'h0, 16, 8, -1);

    // 3: clamp to DEPTH-1 with two channels
    post_len = 10;
    do_arm();
    smp(8'hA, 8'd1, 1);
    for (int k = 2; k <= 7; k++) smp(8'hA, 8'(k), 0);
    chk("t3_still_post", 32'(state), 2);
    smp(8'hA, 8'd8, 0);
    chk("t3_done", 32'(state), 3);
    smp(8'hA, 8'd9, 0);
    chk("t3_count", 32'(count), 8);
    chk("t3_tidx", 32'(trig_idx), 0);
    drain(8'hA, 1, 8, -1);

    // 5: reset during POST, then IDLE ignores input
    post_len = 3;
    do_arm();
    smp(8'h0, 8'd1, 1);
    chk("t5_post", 32'(state), 2);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("t5_state", 32'(state), 0);
    chk("t5_count", 32'(count), 0);
    chk("t5_tidx", 32'(trig_idx), 0);
    chk("t5_valid", 32'(rd_valid), 0);
    chk("t5_last", 32'(rd_last), 0);
    chk("t5_data", 32'(rd_data), 0);
    smp(8'h0, 8'd5, 1);
    smp(8'h0, 8'd6, 0);
    chk("t5_idle_count", 32'(count), 0);
    chk("t5_idle_state", 32'(state), 0);

    // 6: en gating, post_len=0, arm aborting readout, empty-buffer trigger
    do_arm();
    en = 0;
    smp(8'h0, 8'd1, 0);
    smp(8'h0, 8'd2, 1);
    chk("t6_gate_count", 32'(count), 0);
    chk("t6_gate_state", 32'(state), 1);
    en = 1;
    post_len = 0;
    for (int k = 1; k <= 3; k++) smp(8'h0, 8'(k), k == 3);
    chk("t6_done", 32'(state), 3);
    chk("t6_count", 32'(count), 3);
    chk("t6_tidx", 32'(trig_idx), 2);
    @(negedge clk);
    chk("t6_first", 32'(rd_data), 1);
    rd_ready = 1;
    @(negedge clk);
    chk("t6_second", 32'(rd_data), 2);
    arm = 1;
    @(negedge clk);
    arm = 0; rd_ready = 0;
    chk("t6_abort_state", 32'(state), 1);
    chk("t6_abort_valid", 32'(rd_valid), 0);
    chk("t6_abort_count", 32'(count), 0);
    trig = 1;
    @(negedge clk);
    trig = 0;
    chk("t6_empty_done", 32'(state), 3);
    @(negedge clk);
    chk("t6_empty_idle", 32'(state), 0);
    chk("t6_empty_valid", 32'(rd_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Synthesizable, parametrised trace recorder. Replaces print-only simulation logging with an on-chip circular buffer of per-cycle samples, for example {pc, inst} or regfile write data.
- Arms on command and keeps recording while armed. On a trigger (typically the core's error), it records a programmable number of post-trigger samples and then freezes.
- After freezing, it streams the captured window oldest-first over a valid/ready port to a host or console drain.
- Sits beside bbq, with taps driven from datapath signals.

Parameters:
- XLEN, 32, width of one channel word.
- NCH, 2, number of channels per sample; an entry is NCH*XLEN bits.
- DEPTH, 64, number of entries; must be a power of two, >= 4.
- CNT_LEN, $clog2(DEPTH), pointer width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  capture enable; gates sample_valid and trig.
- arm  in  1  single-cycle pulse that clears the buffer and enters ARMED.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  NCH*XLEN  sample; channel k is bits [k*XLEN +: XLEN].
- trig  in  1  trigger event.
- post_len  in  CNT_LEN+1  post-trigger samples to record; sampled at trigger.
- rd_valid  out  1  rd_data holds an entry.
- rd_ready  in  1  consumer accepts the entry.
- rd_data  out  NCH*XLEN  entry, oldest first.
- rd_last  out  1  marks the final entry of the window.
- count  out  CNT_LEN+1  valid entries in the buffer (0..DEPTH).
- trig_idx  out  CNT_LEN+1  readout index of the trigger entry.
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.

Behaviour:
- Reset:
  - state=IDLE; count, trig_idx, rd_data = 0; rd_valid=0, rd_last=0.
  - Internal pointers = 0.
  - Takes priority over every other input in the same cycle.
- Capture:
  - A write occurs when en && sample_valid in ARMED or POST.
  - Data goes to wr_ptr; wr_ptr increments modulo DEPTH.
  - count increments and saturates at DEPTH; once full, the oldest entry is overwritten.
- arm:
  - Honoured in any state, including mid-readout (aborts it).
  - Next cycle: state=ARMED, count=0, wr_ptr=0, rd_valid=0, rd_last=0, trig_idx=0.
  - arm takes priority over trig and writes in the same cycle; a same-cycle sample is not written.
- IDLE: samples and trig ignored.
- ARMED:
  - en && trig:
    - post_rem = min(post_len, DEPTH-1).
    - If sample_valid is also high, that sample is written and is the trigger entry.
    - Otherwise the trigger entry is the most recent written entry.
  - Next state: post_rem==0 -> DONE, else POST.
- POST:
  - Each write decrements post_rem; the write that reaches 0 moves state to DONE next cycle.
  - trig ignored.
  - The DEPTH-1 clamp guarantees the trigger entry is never overwritten.
- DONE entry:
  - trig_idx = count - 1 - post_written, where post_written is the number of post-trigger samples actually written. It is registered on entering DONE.
  - If count==0 (trig with empty buffer and no sample): rd_valid never asserts; state returns to IDLE the following cycle.
  - Otherwise rd_ptr = wr_ptr - count (mod DEPTH).
- DONE readout:
  - Capture is frozen; sample_valid and trig are ignored.
  - rd_valid rises 1 cycle after entering DONE.
  - A transfer occurs when rd_valid && rd_ready. The next entry is presented the following cycle, giving 1 entry/cycle sustained.
  - While rd_valid && !rd_ready, rd_data and rd_last hold stable.
  - rd_last=1 only with entry count-1.
  - After the last transfer: rd_valid=0, rd_last=0, state=IDLE next cycle.
  - count and trig_idx stay valid until the next arm or reset.
- en=0: freezes capture and trig detection in every state; readout is unaffected.

Test Plan:
(DEPTH=8, NCH=1 unless stated)
1. Basic window:
   - Stimulus: arm; samples 1..5 with trig on 5; post_len=2; samples 6,7.
   - Required: state DONE; count=7; trig_idx=4; readout 1..7; rd_last only on 7; then IDLE.
2. Wrap-around:
   - Stimulus: arm; samples 1..20 with trig on 20; post_len=3; samples 21..23.
   - Required: count=8; readout 16..23; trig_idx=4.
3. Clamp and NCH=2:
   - Stimulus: arm; trig on first sample {0xA,0x1}; post_len=10; samples {0xA,k} for k=2..9.
   - Required: DONE after 7 post samples; readout k=1..8; trig_idx=0.
4. Backpressure:
   - Stimulus: during readout of test 1, hold rd_ready=0 for 3 cycles while entry 3 is presented.
   - Required: rd_data=3 and rd_valid=1 stable throughout; no entry lost or duplicated; 7 total transfers.
5. Reset and IDLE:
   - Stimulus: reset asserted in POST.
   - Required: next cycle all outputs 0 and state IDLE; subsequent trig and samples are ignored (count stays 0).
6. Abort and gating:
   - Stimulus: with en=0 in ARMED, apply samples and trig; then arm during DONE readout.
   - Required: en=0 gives count=0 and state unchanged; arm gives state ARMED, rd_valid=0, count=0 the next cycle.
